// File: rtl/sound_mem_arbiter_if.sv
// Bundles the GLU write, DOC read and SDRAM client signals of the sound-RAM arbiter.
// Pure wiring; no latency of its own.
// Backpressure is carried by the signals themselves (glu_full_o, mem_ready_i).
interface sound_mem_arbiter_if;
    // GLU posted-write side
    logic        glu_wr_i;
    logic [20:0] glu_addr_i;
    logic [3:0]  glu_byte_en_i;
    logic [31:0] glu_data_i;
    logic        glu_full_o;
    // DOC wavetable read side
    logic        doc_rd_i;
    logic [20:0] doc_addr_i;
    logic [31:0] doc_q_o;
    logic        doc_ready_o;
    // SDRAM client port
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [20:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_q_i;
    logic        mem_ready_i;
    // status
    logic        busy_o;
    logic        wr_overflow_o;
    logic        rd_collision_o;
    logic        timeout_o;

    // arbiter side
    modport slave (
        input  glu_wr_i, glu_addr_i, glu_byte_en_i, glu_data_i,
        input  doc_rd_i, doc_addr_i,
        input  mem_q_i, mem_ready_i,
        output glu_full_o, doc_q_o, doc_ready_o,
        output mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o,
        output busy_o, wr_overflow_o, rd_collision_o, timeout_o
    );

    // requester / memory side
    modport master (
        output glu_wr_i, glu_addr_i, glu_byte_en_i, glu_data_i,
        output doc_rd_i, doc_addr_i,
        output mem_q_i, mem_ready_i,
        input  glu_full_o, doc_q_o, doc_ready_o,
        input  mem_rd_o, mem_wr_o, mem_addr_o, mem_data_o, mem_byte_en_o,
        input  busy_o, wr_overflow_o, rd_collision_o, timeout_o
    );
endinterface

// File: rtl/sound_mem_arbiter.sv
// Shares one sound-RAM SDRAM client between posted GLU writes (FIFO) and real-time DOC reads.
// Latency: idle DOC read strobes memory next cycle; completion returns one cycle after mem_ready_i.
// Backpressure: full FIFO drops writes (sticky flag); a second read while one is outstanding is dropped.
module sound_mem_arbiter #(
    parameter int unsigned WR_FIFO_DEPTH  = 4,
    parameter int unsigned MAX_RD_STREAK  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] SILENCE_WORD   = 32'h80808080
) (
    input logic                clk_i,
    input logic                reset_i,
    sound_mem_arbiter_if.slave bus
);

    localparam int unsigned PTR_W    = (WR_FIFO_DEPTH > 1) ? $clog2(WR_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned STREAK_W = (MAX_RD_STREAK < 1) ? 1 : $clog2(MAX_RD_STREAK + 1);
    localparam int unsigned WD_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [20:0] addr;
        logic [3:0]  byte_en;
        logic [31:0] data;
    } wr_ent_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t              state;
    wr_ent_t             fifo_mem [WR_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;
    logic [STREAK_W-1:0] rd_streak;
    logic [WD_W-1:0]     wd_cnt;
    logic                rd_pend;
    logic [20:0]         rd_pend_addr;

    logic                fifo_empty;
    logic                fifo_full;
    logic                rd_busy;
    logic                rd_accept;
    logic                rd_req;
    logic [20:0]         rd_req_addr;
    logic                streak_ok;
    logic                grant_rd;
    logic                grant_wr;
    logic                push;
    logic                pop;
    logic                wd_expired;
    wr_ent_t             head;

    // Arbitration and FIFO bookkeeping; a fresh DOC request bypasses the slot so an idle read issues next cycle
    always_comb begin
        fifo_empty  = (count == '0);
        fifo_full   = (count == CNT_W'(WR_FIFO_DEPTH));
        rd_busy     = rd_pend || (state == RD_WAIT);
        rd_accept   = bus.doc_rd_i && !rd_busy;
        rd_req      = rd_pend || rd_accept;
        rd_req_addr = rd_pend ? rd_pend_addr : bus.doc_addr_i;
        streak_ok   = (rd_streak < STREAK_W'(MAX_RD_STREAK));
        grant_rd    = (state == IDLE) && rd_req && (fifo_empty || streak_ok);
        grant_wr    = (state == IDLE) && !grant_rd && !fifo_empty;
        pop         = grant_wr;
        // a pop in the same cycle frees the slot the push needs
        push        = bus.glu_wr_i && (!fifo_full || pop);
        count_nxt   = count + CNT_W'(push) - CNT_W'(pop);
        wd_expired  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
        head        = fifo_mem[rd_ptr];
    end

    // Write FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{addr: bus.glu_addr_i, byte_en: bus.glu_byte_en_i, data: bus.glu_data_i};
        end
    end

    // Write FIFO pointers, occupancy and the registered full flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            bus.glu_full_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count          <= count_nxt;
            bus.glu_full_o <= (count_nxt == CNT_W'(WR_FIFO_DEPTH));
        end
    end

    // Single-entry pending read slot plus the sticky drop flags
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_pend            <= 1'b0;
            rd_pend_addr       <= '0;
            bus.rd_collision_o <= 1'b0;
            bus.wr_overflow_o  <= 1'b0;
        end else begin
            if (rd_accept && !grant_rd) begin
                rd_pend      <= 1'b1;
                rd_pend_addr <= bus.doc_addr_i;
            end else if (grant_rd && rd_pend) begin
                rd_pend <= 1'b0;
            end
            if (bus.doc_rd_i && rd_busy) bus.rd_collision_o <= 1'b1;
            if (bus.glu_wr_i && !push)   bus.wr_overflow_o  <= 1'b1;
        end
    end

    // Access FSM: issues one access at a time, waits for completion or watchdog expiry
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state             <= IDLE;
            bus.mem_rd_o      <= 1'b0;
            bus.mem_wr_o      <= 1'b0;
            bus.mem_addr_o    <= '0;
            bus.mem_data_o    <= '0;
            bus.mem_byte_en_o <= '0;
            bus.doc_q_o       <= '0;
            bus.doc_ready_o   <= 1'b0;
            bus.busy_o        <= 1'b0;
            bus.timeout_o     <= 1'b0;
            rd_streak         <= '0;
            wd_cnt            <= '0;
        end else begin
            bus.mem_rd_o    <= 1'b0;
            bus.mem_wr_o    <= 1'b0;
            bus.doc_ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        bus.mem_rd_o      <= 1'b1;
                        bus.mem_addr_o    <= rd_req_addr;
                        bus.mem_data_o    <= '0;
                        bus.mem_byte_en_o <= 4'b1111;
                        bus.busy_o        <= 1'b1;
                        wd_cnt            <= '0;
                        state             <= RD_WAIT;
                        // streak only counts reads that overtook a waiting write
                        if (fifo_empty)     rd_streak <= '0;
                        else if (streak_ok) rd_streak <= rd_streak + STREAK_W'(1);
                    end else if (grant_wr) begin
                        bus.mem_wr_o      <= 1'b1;
                        bus.mem_addr_o    <= head.addr;
                        bus.mem_data_o    <= head.data;
                        bus.mem_byte_en_o <= head.byte_en;
                        bus.busy_o        <= 1'b1;
                        wd_cnt            <= '0;
                        rd_streak         <= '0;
                        state             <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (bus.mem_ready_i) begin
                        bus.doc_q_o     <= bus.mem_q_i;
                        bus.doc_ready_o <= 1'b1;
                        bus.busy_o      <= 1'b0;
                        state           <= IDLE;
                    end else if (wd_expired) begin
                        // DOC must always get an answer; mid-scale keeps the audio quiet
                        bus.doc_q_o     <= SILENCE_WORD;
                        bus.doc_ready_o <= 1'b1;
                        bus.timeout_o   <= 1'b1;
                        bus.busy_o      <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                WR_WAIT: begin
                    if (bus.mem_ready_i) begin
                        bus.busy_o <= 1'b0;
                        state      <= IDLE;
                    end else if (wd_expired) begin
                        bus.timeout_o <= 1'b1;
                        bus.busy_o    <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_mem_arbiter.sv
// Scoreboard bench for sound_mem_arbiter: directed scenarios plus a randomized phase.
// Expected reads/writes are queued at stimulus time and checked by an independent monitor.
// A behavioural memory responder supplies configurable latency or stalls.
module tb_sound_mem_arbiter;

    localparam int          DEPTH  = 4;
    localparam int          STREAK = 4;
    localparam int          TMO    = 64;
    localparam logic [31:0] SIL    = 32'h80808080;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    // cycle counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    sound_mem_arbiter_if bus ();

    sound_mem_arbiter #(
        .WR_FIFO_DEPTH (DEPTH),
        .MAX_RD_STREAK (STREAK),
        .TIMEOUT_CYCLES(TMO),
        .SILENCE_WORD  (SIL)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // scoreboard state
    logic [20:0] rd_q   [$];
    logic [31:0] rdat_q [$];
    logic [56:0] wr_q   [$];
    byte         log_q  [$];
    int          pushes = 0;
    int          wr_pops = 0;
    bit          rd_out = 0;
    bit          coll_exp = 0;
    bit          ovf_exp = 0;
    int          last_rd_cyc = 0;
    int          last_done_cyc = 0;
    int          done_cnt = 0;

    // memory responder knobs
    bit          mem_stall = 0;
    int          lat_min = 3;
    int          lat_max = 3;
    bit          resp_pend = 0;
    bit          force_ready = 0;

    function automatic logic [31:0] rdata(input logic [20:0] a);
        if (a == 21'h10004) return 32'hDEADBEEF;
        return {a[10:0], a} ^ 32'h5A5AC3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected event, required none", name);
    endtask

    // memory responder: answers each strobe after a random latency unless stalled
    initial begin : responder
        int cnt;
        logic [31:0] q;
        cnt = 0;
        q = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready_i = 1'b0;
            if (bus.mem_rd_o || bus.mem_wr_o) begin
                resp_pend = 1;
                cnt = $urandom_range(lat_max, lat_min);
                q = bus.mem_rd_o ? rdata(bus.mem_addr_o) : $urandom;
            end
            if (force_ready) begin
                bus.mem_ready_i = 1'b1;
                bus.mem_q_i = $urandom;
                force_ready = 0;
            end else if (resp_pend && !mem_stall) begin
                if (cnt == 0) begin
                    bus.mem_ready_i = 1'b1;
                    bus.mem_q_i = q;
                    resp_pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a strobe or completion
    initial begin : monitor
        logic [20:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.mem_rd_o && bus.mem_wr_o) fail("dual_strobe");
                if (bus.mem_rd_o) begin
                    last_rd_cyc = cyc;
                    log_q.push_back(8'h52);
                    if (rd_q.size() == 0) fail("rd_unexpected");
                    else begin
                        a = rd_q.pop_front();
                        check("rd_addr", bus.mem_addr_o, a);
                        check("rd_byte_en", bus.mem_byte_en_o, 4'hF);
                        rdat_q.push_back(mem_stall ? SIL : rdata(a));
                    end
                end
                if (bus.mem_wr_o) begin
                    wr_pops++;
                    log_q.push_back(8'h57);
                    if (wr_q.size() == 0) fail("wr_unexpected");
                    else check("wr_entry", {bus.mem_addr_o, bus.mem_byte_en_o, bus.mem_data_o}, wr_q.pop_front());
                end
                if (bus.doc_ready_o) begin
                    last_done_cyc = cyc;
                    done_cnt++;
                    rd_out = 0;
                    if (rdat_q.size() == 0) fail("done_unexpected");
                    else check("doc_q", bus.doc_q_o, rdat_q.pop_front());
                end
            end
        end
    end

    task automatic next_cyc();
        @(negedge clk);
        #1;
        bus.glu_wr_i = 1'b0;
        bus.doc_rd_i = 1'b0;
    endtask

    task automatic doc_req(input logic [20:0] a);
        bus.doc_rd_i = 1'b1;
        bus.doc_addr_i = a;
        if (!rd_out) begin
            rd_q.push_back(a);
            rd_out = 1;
        end else begin
            coll_exp = 1;
        end
    endtask

    task automatic glu_push(input logic [20:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.glu_wr_i = 1'b1;
        bus.glu_addr_i = a;
        bus.glu_byte_en_i = be;
        bus.glu_data_i = d;
        if (pushes - wr_pops < DEPTH) begin
            wr_q.push_back({a, be, d});
            pushes++;
        end else begin
            ovf_exp = 1;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            next_cyc();
            n++;
        end
        if (done_cnt == start) fail(name);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((rd_q.size() + rdat_q.size() + wr_q.size() != 0 || rd_out || bus.busy_o) && n < budget) begin
            next_cyc();
            n++;
        end
        check(name, rd_q.size() + rdat_q.size() + wr_q.size() + int'(rd_out) + int'(bus.busy_o), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strobes"}, {bus.mem_rd_o, bus.mem_wr_o, bus.doc_ready_o, bus.busy_o, bus.glu_full_o}, 0);
        check({tag, "_flags"}, {bus.wr_overflow_o, bus.rd_collision_o, bus.timeout_o}, 0);
        check({tag, "_doc_q"}, bus.doc_q_o, 0);
        check({tag, "_mem_bus"}, {bus.mem_addr_o, bus.mem_byte_en_o, bus.mem_data_o}, 0);
    endtask

    // directed and random stimulus
    initial begin : driver
        int req_cyc;
        int start;
        int pops0;
        int n;
        int logn;
        logic [55:0] got_s;
        logic [55:0] want_s;

        bus.glu_wr_i = 1'b0;
        bus.glu_addr_i = '0;
        bus.glu_byte_en_i = '0;
        bus.glu_data_i = '0;
        bus.doc_rd_i = 1'b0;
        bus.doc_addr_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        next_cyc();

        // idle read, memory ready 3 cycles after the strobe
        lat_min = 3; lat_max = 3;
        doc_req(21'h10004);
        req_cyc = cyc;
        next_cyc();
        wait_done("idle_read_done", 20);
        check("idle_rd_latency", last_rd_cyc - req_cyc, 1);
        check("idle_done_latency", last_done_cyc - last_rd_cyc, 4);
        check("idle_doc_q", bus.doc_q_o, 32'hDEADBEEF);
        next_cyc();

        // collision: second request while the first is in flight
        lat_min = 10; lat_max = 10;
        start = done_cnt;
        doc_req(21'h00A00);
        next_cyc();
        repeat (3) next_cyc();
        doc_req(21'h00B00);
        next_cyc();
        check("rd_collision", bus.rd_collision_o, coll_exp);
        wait_done("collision_done", 30);
        repeat (20) next_cyc();
        check("collision_one_done", done_cnt - start, 1);

        // timeout read with the FSM busy, then write burst overflowing the FIFO
        lat_min = 3; lat_max = 3;
        mem_stall = 1;
        doc_req(21'h00123);
        next_cyc();
        pops0 = wr_pops;
        for (int i = 0; i < 5; i++) begin
            glu_push(21'h00200 + 21'(i), 4'(i + 1), 32'hC0DE0000 + i);
            next_cyc();
            check("glu_full", bus.glu_full_o, (pushes - wr_pops) == DEPTH);
        end
        check("wr_overflow", bus.wr_overflow_o, ovf_exp);
        mem_stall = 0;
        resp_pend = 0;
        wait_done("timeout_done", 120);
        check("timeout_latency", last_done_cyc - last_rd_cyc, TMO);
        check("timeout_flag", bus.timeout_o, 1);
        wait_drain("burst_drain", 100);
        check("burst_pops", wr_pops - pops0, DEPTH);

        // starvation: continuous reads with one write waiting
        lat_min = 2; lat_max = 2;
        log_q.delete();
        doc_req(21'h01000);
        next_cyc();
        glu_push(21'h0ABCD, 4'b0101, 32'h12345678);
        next_cyc();
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (rd_out && n < 50) begin
                next_cyc();
                n++;
            end
            if (rd_out) fail("starve_wait");
            doc_req(21'h01001 + 21'(k));
            next_cyc();
        end
        wait_drain("starve_drain", 100);
        logn = log_q.size();
        check("starve_len", logn, 7);
        got_s = '0;
        for (int i = 0; i < logn && i < 7; i++) got_s = {got_s[47:0], log_q[i]};
        want_s = "RRRRRWR";
        check("starve_order", got_s, want_s);

        // randomized mix within FIFO capacity
        lat_min = 0; lat_max = 5;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3, 0) == 0) doc_req(21'($urandom));
            if ($urandom_range(2, 0) == 0 && (pushes - wr_pops) < DEPTH)
                glu_push(21'($urandom), 4'($urandom), $urandom);
            next_cyc();
        end
        wait_drain("rand_drain", 600);
        check("rand_collision", bus.rd_collision_o, coll_exp);
        check("rand_overflow", bus.wr_overflow_o, ovf_exp);

        // reset in the middle of a write, then a late ready
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            glu_push(21'h1F000 + 21'(i), 4'hF, 32'hFEED0000 + i);
            next_cyc();
        end
        check("pre_reset_busy", bus.busy_o, 1);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        rd_q.delete(); rdat_q.delete(); wr_q.delete();
        pushes = 0; wr_pops = 0; rd_out = 0;
        coll_exp = 0; ovf_exp = 0;
        resp_pend = 0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
        mem_stall = 0;
        logn = log_q.size();
        force_ready = 1;
        repeat (15) next_cyc();
        check("post_reset_no_strobe", log_q.size() - logn, 0);
        check_zero("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard bound in case the DUT wedges a wait loop
    initial begin : guard
        #1000000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/sound_mem_arbiter.md
Name: sound_mem_arbiter

Overview:
- Shares the single sound-RAM SDRAM client port between two requesters:
  - GLU CPU-side writes: posted, fire-and-forget.
  - DOC5503 wavetable reads: real-time, latency-sensitive.
- Sits between the GLU register logic / DOC wave fetch and one sdram_port_if client.
- GLU writes are buffered in a small FIFO. DOC reads get priority, bounded by a starvation limit.
- A watchdog guarantees the DOC always receives a completion.

Parameters:
- WR_FIFO_DEPTH, 4: GLU write FIFO entries; power of two, 2..16.
- MAX_RD_STREAK, 4: maximum consecutive read grants while a write is waiting.
- TIMEOUT_CYCLES, 64: cycles to wait for mem_ready_i before aborting an access.
- SILENCE_WORD, 32'h80808080: read data returned on a timed-out read (8-bit midpoint in every byte).

Ports:
- clk_i  in  1  logic clock (clk_logic domain)
- reset_i  in  1  asynchronous, active-high reset
- glu_wr_i  in  1  one-cycle write request
- glu_addr_i  in  21  word address
- glu_byte_en_i  in  4  byte enables
- glu_data_i  in  32  write data
- glu_full_o  out  1  FIFO full
- doc_rd_i  in  1  one-cycle read request
- doc_addr_i  in  21  word address
- doc_q_o  out  32  read data
- doc_ready_o  out  1  one-cycle read completion
- mem_rd_o  out  1  one-cycle read strobe to SDRAM port
- mem_wr_o  out  1  one-cycle write strobe
- mem_addr_o  out  21  access address
- mem_data_o  out  32  write data
- mem_byte_en_o  out  4  byte enables (4'b1111 on reads)
- mem_q_i  in  32  read data from SDRAM port
- mem_ready_i  in  1  access complete
- busy_o  out  1  access outstanding
- wr_overflow_o  out  1  sticky: write dropped because FIFO full
- rd_collision_o  out  1  sticky: DOC read arrived while a read was already pending or in flight
- timeout_o  out  1  sticky: an access timed out

Behaviour:
- Reset (asynchronous, reset_i=1):
  - All outputs 0, FIFO empty, FSM in IDLE.
  - Sticky flags cleared only by reset.
  - Reset mid-access abandons the access; a late mem_ready_i after reset is ignored because the FSM is in IDLE.
- Only one memory access is outstanding at a time. Each mem_rd_o/mem_wr_o is a single-cycle pulse; mem_addr_o, mem_data_o and mem_byte_en_o are held stable until completion.
- Write FIFO:
  - glu_wr_i pushes {addr, byte_en, data}.
  - Push while full drops the entry and sets wr_overflow_o.
  - glu_full_o is registered and reflects the count after this cycle's push/pop.
  - Simultaneous push and pop when full: pop frees a slot first; no drop.
- Read slot:
  - doc_rd_i latches doc_addr_i into a single pending slot.
  - If the slot is already full or a read is in flight, the request is ignored and rd_collision_o is set.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE arbitration, one decision per cycle:
  - Read pending and (FIFO empty or rd_streak < MAX_RD_STREAK): issue the read, go to RD_WAIT; rd_streak increments, saturating.
  - Otherwise, FIFO not empty: pop the head, issue the write, go to WR_WAIT; rd_streak clears to 0.
  - rd_streak also clears whenever the FIFO is empty at a grant.
- Latency:
  - doc_rd_i at cycle N in IDLE with no contention gives mem_rd_o at N+1.
  - A pending read is visible to the arbiter the cycle after capture.
- RD_WAIT:
  - mem_ready_i at cycle M: doc_q_o <= mem_q_i and doc_ready_o=1 at M+1; FSM back to IDLE at M+1.
  - doc_q_o holds its value until the next completion.
- WR_WAIT: mem_ready_i returns the FSM to IDLE; nothing is signalled to the GLU.
- Watchdog:
  - Counter resets on every issue.
  - Reaching TIMEOUT_CYCLES without mem_ready_i sets timeout_o and returns to IDLE.
  - Read timeout: doc_q_o=SILENCE_WORD, doc_ready_o pulses.
  - Write timeout: the write is discarded.
- busy_o=1 in RD_WAIT/WR_WAIT.
- mem_ready_i in IDLE is ignored.
- Back-to-back: the next issue can occur at the cycle after a completion is registered, i.e. M+1.

Test Plan:
- Idle read: doc_rd_i addr 21'h10004; ready 3 cycles after mem_rd_o with q=32'hDEADBEEF -> mem_rd_o at N+1, doc_ready_o one cycle after ready, doc_q_o=DEADBEEF.
- Write burst: 5 glu_wr_i on consecutive cycles, memory never ready -> glu_full_o after 4th push, 5th dropped, wr_overflow_o=1; FIFO order preserved after ready resumes.
- Starvation: continuous DOC reads with one write queued, MAX_RD_STREAK=4 -> exactly 4 reads, then the write, then reads resume.
- Timeout: read issued, mem_ready_i never asserted -> after 64 cycles doc_ready_o pulses with doc_q_o=80808080, timeout_o=1.
- Collision: second doc_rd_i while the first read is in flight -> ignored, rd_collision_o=1, only one doc_ready_o.
- Reset mid-write: assert reset_i during WR_WAIT, then late mem_ready_i -> all outputs 0, FIFO empty, no spurious strobes.
